ntt_addr_gen: RTL and testbench

//   Address/twiddle generator directly downstream of the mixed-radix stage controller (128-point transform:
//   one radix-2 stage of span 64, then three radix-4 stages over two 64-point halves). Converts loop

---
 rtl/ntt_addr_gen.sv | 171 +++++++++++++++++
 tb/tb_ntt_addr_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen
//   Address and twiddle generator for a 128-point mixed-radix transform.
//   It turns the controller's loop indices into four data-memory read
//   addresses and three twiddle-ROM exponents for the 4-input butterfly.
//   Each issued read set is then delayed to become the matching write-back
//   address set once the butterfly result is ready.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   sel             0 = radix-2 issue, 1 = radix-4 issue
//   en              one butterfly issue this cycle
//   i               radix-2 pair index
//   k, j, p         radix-4 group index, in-group index, stage (span 4^p)
//   raddr0..3       read addresses for legs 0..3 (1-cycle issue latency)
//   tw1..3          twiddle exponents for legs 1..3
//   rvalid          raddr*/tw* carry a fresh issue
//   waddr0..3       write-back addresses aligned with butterfly outputs
//   wvalid          waddr* carry a fresh result
//   err             sticky: illegal p or radix-2/radix-4 write collision
module ntt_addr_gen #(
    parameter int AW     = 7,
    parameter int LAT_R2 = 8,
    parameter int LAT_R4 = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          en,
    input  logic [4:0]    i,
    input  logic [4:0]    k,
    input  logic [4:0]    j,
    input  logic [2:0]    p,
    output logic [AW-1:0] raddr0,
    output logic [AW-1:0] raddr1,
    output logic [AW-1:0] raddr2,
    output logic [AW-1:0] raddr3,
    output logic [AW-1:0] tw1,
    output logic [AW-1:0] tw2,
    output logic [AW-1:0] tw3,
    output logic          rvalid,
    output logic [AW-1:0] waddr0,
    output logic [AW-1:0] waddr1,
    output logic [AW-1:0] waddr2,
    output logic [AW-1:0] waddr3,
    output logic          wvalid,
    output logic          err
);
    // Intermediate arithmetic is carried wide and truncated at the end,
    // which gives the mod-2^AW result the address space wraps on.
    localparam int CW = 12;
    // Delay-line entry: {valid, mode, raddr3, raddr2, raddr1, raddr0}
    localparam int EW = 2 + 4 * AW;

    logic          p_bad;
    logic [1:0]    p_eff;
    logic [2:0]    s;
    logic [CW-1:0] base;
    logic [CW-1:0] e;

    logic [AW-1:0] raddr_d [4];
    logic [AW-1:0] raddr_q [4];
    logic [AW-1:0] tw_d    [1:3];
    logic [AW-1:0] tw_q    [1:3];
    logic [AW-1:0] waddr_d [4];
    logic [AW-1:0] waddr_q [4];
    logic          rvalid_d, rvalid_q;
    logic          mode_d, mode_q;
    logic          wvalid_d, wvalid_q;
    logic          err_d, err_q;

    logic [EW-1:0] line_d [LAT_R4];
    logic [EW-1:0] line_q [LAT_R4];
    logic [EW-1:0] tap_a, tap_b;
    logic          hit_a, hit_b;

    // Radix-4 index decode; an out-of-range stage is computed as the last
    // legal stage so the datapath still sees a well-formed address set.
    always_comb begin
        p_bad = sel && en && (p > 3'd2);
        p_eff = (p > 3'd2) ? 2'd2 : p[1:0];
        s     = {p_eff, 1'b0};
        base  = (CW'(k) << (s + 3'd2)) + CW'(j);
        e     = CW'(j) << (3'd4 - s);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_raddr
            assign raddr_d[gi] = !en ? raddr_q[gi] :
                                 sel ? AW'(base + (CW'(gi) << s)) :
                                       AW'(CW'(i) + CW'(32 * gi));
        end
        // Radix-2 uses only legs 1 and 2 for twiddles; leg 3 exponent is 0.
        for (gi = 1; gi < 4; gi++) begin : g_tw
            assign tw_d[gi] = !en ? tw_q[gi] :
                              sel ? AW'(CW'(2 * gi) * e) :
                              (gi == 3) ? '0 : AW'(CW'(i) + CW'(32 * (gi - 1)));
        end
    endgenerate

    assign rvalid_d = en;
    assign mode_d   = en ? sel : mode_q;

    // Every entry carries its own mode bit, so sel may change freely while
    // older entries are still travelling down the line.
    assign line_d[0] = {rvalid_q, mode_q, raddr_q[3], raddr_q[2], raddr_q[1], raddr_q[0]};
    generate
        for (gi = 1; gi < LAT_R4; gi++) begin : g_line
            assign line_d[gi] = line_q[gi-1];
        end
    endgenerate

    // Radix-2 results emerge from the short tap, radix-4 from the end of the
    // line; if both fire together the radix-2 result wins and the radix-4
    // entry is lost, which is flagged as an error.
    assign tap_a = line_q[LAT_R2-1];
    assign tap_b = line_q[LAT_R4-1];
    assign hit_a = tap_a[EW-1] & ~tap_a[EW-2];
    assign hit_b = tap_b[EW-1] &  tap_b[EW-2];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_waddr
            assign waddr_d[gi] = hit_a ? tap_a[gi*AW +: AW] :
                                 hit_b ? tap_b[gi*AW +: AW] : waddr_q[gi];
        end
    endgenerate

    assign wvalid_d = hit_a | hit_b;
    assign err_d    = err_q | p_bad | (hit_a & hit_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                raddr_q[n] <= '0;
                waddr_q[n] <= '0;
            end
            for (int n = 1; n < 4; n++) tw_q[n] <= '0;
            for (int n = 0; n < LAT_R4; n++) line_q[n] <= '0;
            rvalid_q <= 1'b0;
            mode_q   <= 1'b0;
            wvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                raddr_q[n] <= raddr_d[n];
                waddr_q[n] <= waddr_d[n];
            end
            for (int n = 1; n < 4; n++) tw_q[n] <= tw_d[n];
            for (int n = 0; n < LAT_R4; n++) line_q[n] <= line_d[n];
            rvalid_q <= rvalid_d;
            mode_q   <= mode_d;
            wvalid_q <= wvalid_d;
            err_q    <= err_d;
        end
    end

    assign raddr0 = raddr_q[0];
    assign raddr1 = raddr_q[1];
    assign raddr2 = raddr_q[2];
    assign raddr3 = raddr_q[3];
    assign tw1    = tw_q[1];
    assign tw2    = tw_q[2];
    assign tw3    = tw_q[3];
    assign rvalid = rvalid_q;
    assign waddr0 = waddr_q[0];
    assign waddr1 = waddr_q[1];
    assign waddr2 = waddr_q[2];
    assign waddr3 = waddr_q[3];
    assign wvalid = wvalid_q;
    assign err    = err_q;
endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: a formula-level model predicts every output each
// cycle, and directed vectors pin the model with hand-computed values.
module tb_ntt_addr_gen;
    localparam int LAT_R2 = 8;
    localparam int LAT_R4 = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       en  = 1'b0;
    logic [4:0] i = '0, k = '0, j = '0;
    logic [2:0] p = '0;
    logic [6:0] raddr0, raddr1, raddr2, raddr3, tw1, tw2, tw3;
    logic [6:0] waddr0, waddr1, waddr2, waddr3;
    logic       rvalid, wvalid, err;

    ntt_addr_gen #(.AW(7), .LAT_R2(LAT_R2), .LAT_R4(LAT_R4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .i(i), .k(k), .j(j), .p(p),
        .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
        .tw1(tw1), .tw2(tw2), .tw3(tw3), .rvalid(rvalid),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3),
        .wvalid(wvalid), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    int m_raddr [4];
    int m_tw    [4];
    int m_waddr [4];
    int m_rvalid = 0, m_wvalid = 0, m_err = 0;
    bit r2_v [32];
    bit r4_v [32];
    int r2_a [32][4];
    int r4_a [32][4];
    int rd_hits [128];
    int wr_cnt = 0;

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            m_raddr[m] = 0; m_tw[m] = 0; m_waddr[m] = 0;
        end
        m_rvalid = 0; m_wvalid = 0; m_err = 0;
        for (int s = 0; s < 32; s++) begin
            r2_v[s] = 1'b0; r4_v[s] = 1'b0;
        end
    endtask

    // Compare-and-predict process: at each falling edge check what the
    // DUT shows now, then predict what it must show after the next rise.
    initial begin
        int cyc;
        int a [4];
        int t [4];
        int pe, span, base, e, slot, ws;
        cyc = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("rvalid", rvalid, m_rvalid);
            chk("wvalid", wvalid, m_wvalid);
            chk("err", err, m_err);
            chk("raddr0", raddr0, m_raddr[0]);
            chk("raddr1", raddr1, m_raddr[1]);
            chk("raddr2", raddr2, m_raddr[2]);
            chk("raddr3", raddr3, m_raddr[3]);
            chk("tw1", tw1, m_tw[1]);
            chk("tw2", tw2, m_tw[2]);
            chk("tw3", tw3, m_tw[3]);
            chk("waddr0", waddr0, m_waddr[0]);
            chk("waddr1", waddr1, m_waddr[1]);
            chk("waddr2", waddr2, m_waddr[2]);
            chk("waddr3", waddr3, m_waddr[3]);
            if (rvalid) begin
                rd_hits[raddr0]++; rd_hits[raddr1]++;
                rd_hits[raddr2]++; rd_hits[raddr3]++;
            end
            if (wvalid) wr_cnt++;

            if (!rst) begin
                m_rvalid = int'(en);
                if (en) begin
                    if (sel) begin
                        pe   = (p > 2) ? 2 : int'(p);
                        span = 4 ** pe;
                        base = int'(k) * 4 * span + int'(j);
                        e    = int'(j) * 16 / span;
                        for (int m = 0; m < 4; m++) begin
                            a[m] = (base + m * span) % 128;
                            t[m] = (2 * m * e) % 128;
                        end
                        if (p > 2) m_err = 1;
                    end else begin
                        for (int m = 0; m < 4; m++) a[m] = (int'(i) + 32 * m) % 128;
                        t[1] = int'(i); t[2] = int'(i) + 32; t[3] = 0;
                    end
                    for (int m = 0; m < 4; m++) m_raddr[m] = a[m];
                    for (int m = 1; m < 4; m++) m_tw[m] = t[m];
                    slot = (cyc + (sel ? LAT_R4 : LAT_R2) + 2) % 32;
                    if (sel) begin
                        r4_v[slot] = 1'b1;
                        for (int m = 0; m < 4; m++) r4_a[slot][m] = a[m];
                    end else begin
                        r2_v[slot] = 1'b1;
                        for (int m = 0; m < 4; m++) r2_a[slot][m] = a[m];
                    end
                end
                ws = (cyc + 1) % 32;
                if (r2_v[ws]) begin
                    m_wvalid = 1;
                    for (int m = 0; m < 4; m++) m_waddr[m] = r2_a[ws][m];
                    if (r4_v[ws]) m_err = 1;
                end else if (r4_v[ws]) begin
                    m_wvalid = 1;
                    for (int m = 0; m < 4; m++) m_waddr[m] = r4_a[ws][m];
                end else begin
                    m_wvalid = 0;
                end
                r2_v[ws] = 1'b0;
                r4_v[ws] = 1'b0;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s_sel, input int ii, input int kk, input int jj, input int pp);
        sel = s_sel; i = 5'(ii); k = 5'(kk); j = 5'(jj); p = 3'(pp);
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_w(output int n);
        n = 0;
        while (!wvalid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_cov();
        for (int a = 0; a < 128; a++) rd_hits[a] = 0;
        wr_cnt = 0;
    endtask

    task automatic sweep_done(input string nm);
        int bad;
        repeat (20) tick();
        bad = 0;
        for (int a = 0; a < 128; a++) if (rd_hits[a] != 1) bad++;
        chk({nm, "_reads_not_once"}, bad, 0);
        chk({nm, "_writes"}, wr_cnt, 32);
        $display("sweep %s: writes=%0d", nm, wr_cnt);
    endtask

    initial begin
        int n, cnt;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_rvalid", rvalid, 0);
        chk("reset_wvalid", wvalid, 0);
        chk("reset_err", err, 0);
        chk("reset_raddr0", raddr0, 0);

        // Radix-2 i=5
        issue(1'b0, 5, 0, 0, 0);
        $display("r2 i=5: raddr=%0d,%0d,%0d,%0d tw=%0d,%0d,%0d", raddr0, raddr1, raddr2, raddr3, tw1, tw2, tw3);
        chk("r2_rvalid", rvalid, 1);
        chk("r2_raddr0", raddr0, 5);  chk("r2_raddr1", raddr1, 37);
        chk("r2_raddr2", raddr2, 69); chk("r2_raddr3", raddr3, 101);
        chk("r2_tw1", tw1, 5); chk("r2_tw2", tw2, 37); chk("r2_tw3", tw3, 0);
        wait_w(n);
        chk("r2_wlat", n, 9);
        chk("r2_waddr0", waddr0, 5);  chk("r2_waddr1", waddr1, 37);
        chk("r2_waddr2", waddr2, 69); chk("r2_waddr3", waddr3, 101);

        // Radix-4 p=2 k=1 j=3
        issue(1'b1, 0, 1, 3, 2);
        $display("r4 p=2 k=1 j=3: raddr=%0d,%0d,%0d,%0d tw=%0d,%0d,%0d", raddr0, raddr1, raddr2, raddr3, tw1, tw2, tw3);
        chk("r4p2_raddr0", raddr0, 67); chk("r4p2_raddr1", raddr1, 83);
        chk("r4p2_raddr2", raddr2, 99); chk("r4p2_raddr3", raddr3, 115);
        chk("r4p2_tw1", tw1, 6); chk("r4p2_tw2", tw2, 12); chk("r4p2_tw3", tw3, 18);
        wait_w(n);
        chk("r4_wlat", n, 15);
        chk("r4_waddr0", waddr0, 67); chk("r4_waddr3", waddr3, 115);

        // Radix-4 p=1 k=2 j=3 and p=0 k=31 j=0
        issue(1'b1, 0, 2, 3, 1);
        $display("r4 p=1 k=2 j=3: raddr=%0d,%0d,%0d,%0d tw=%0d,%0d,%0d", raddr0, raddr1, raddr2, raddr3, tw1, tw2, tw3);
        chk("r4p1_raddr0", raddr0, 35); chk("r4p1_raddr1", raddr1, 39);
        chk("r4p1_raddr2", raddr2, 43); chk("r4p1_raddr3", raddr3, 47);
        chk("r4p1_tw1", tw1, 24); chk("r4p1_tw2", tw2, 48); chk("r4p1_tw3", tw3, 72);
        issue(1'b1, 0, 31, 0, 0);
        $display("r4 p=0 k=31 j=0: raddr=%0d,%0d,%0d,%0d tw=%0d,%0d,%0d", raddr0, raddr1, raddr2, raddr3, tw1, tw2, tw3);
        chk("r4p0_raddr0", raddr0, 124); chk("r4p0_raddr3", raddr3, 127);
        chk("r4p0_tw1", tw1, 0); chk("r4p0_tw3", tw3, 0);
        tick();
        chk("idle_rvalid", rvalid, 0);
        chk("idle_hold_raddr0", raddr0, 124);
        repeat (20) tick();

        // Full sweeps, en continuous within each stage
        clear_cov();
        sel = 1'b0; en = 1'b1;
        for (int ii = 0; ii < 32; ii++) begin i = 5'(ii); tick(); end
        en = 1'b0;
        sweep_done("r2");
        for (int pp = 2; pp >= 0; pp--) begin
            int span;
            span = 4 ** pp;
            clear_cov();
            sel = 1'b1; p = 3'(pp); en = 1'b1;
            for (int kk = 0; kk < 64 / (4 * span) * 2; kk++)
                for (int jj = 0; jj < span; jj++) begin
                    k = 5'(kk); j = 5'(jj); tick();
                end
            en = 1'b0;
            sweep_done($sformatf("r4p%0d", pp));
        end

        // Reset with 5 entries in flight
        sel = 1'b0; en = 1'b1;
        for (int ii = 0; ii < 5; ii++) begin i = 5'(10 + ii); tick(); end
        en = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        $display("mid reset: rvalid=%0d wvalid=%0d raddr0=%0d waddr0=%0d err=%0d", rvalid, wvalid, raddr0, waddr0, err);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_wvalid", wvalid, 0);
        chk("midrst_raddr0", raddr0, 0);
        chk("midrst_waddr0", waddr0, 0);
        chk("midrst_err", err, 0);
        repeat (2) tick();
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin tick(); if (wvalid) cnt++; end
        chk("midrst_no_wvalid", cnt, 0);

        // Collision: radix-4 issue, radix-2 issue six cycles later
        issue(1'b1, 0, 0, 1, 2);
        repeat (5) tick();
        issue(1'b0, 7, 0, 0, 0);
        wait_w(n);
        $display("collision: wlat=%0d waddr0=%0d err=%0d", n, waddr0, err);
        chk("coll_wlat", n, 9);
        chk("coll_waddr0", waddr0, 7);
        chk("coll_waddr3", waddr3, 103);
        chk("coll_err", err, 1);
        cnt = 0;
        repeat (20) begin tick(); if (wvalid) cnt++; end
        chk("coll_r4_dropped", cnt, 0);

        // Reset clears err, then illegal p=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_clears_err", err, 0);
        issue(1'b1, 0, 1, 3, 3);
        $display("r4 p=3 k=1 j=3: raddr=%0d,%0d,%0d,%0d tw=%0d,%0d,%0d err=%0d", raddr0, raddr1, raddr2, raddr3, tw1, tw2, tw3, err);
        chk("p3_raddr0", raddr0, 67); chk("p3_raddr1", raddr1, 83);
        chk("p3_raddr2", raddr2, 99); chk("p3_raddr3", raddr3, 115);
        chk("p3_tw2", tw2, 12);
        chk("p3_err", err, 1);
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
